// File: rtl/xy_port_allocator.sv
// Output-port allocator for a 5-port XY router: decodes each head flit's route,
// grants free outputs with a per-output round-robin and tracks ownership until packet end.
module xy_port_allocator #(
   parameter logic [7:0] ADDRESS  = 8'h00,
   parameter int         TAM_FLIT = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4:0]              h,
   input  logic [5*TAM_FLIT-1:0]   data_in,
   input  logic [4:0]              sender,
   output logic [4:0]              ack_h,
   output logic [4:0]              free,
   output logic [14:0]             mux_in,
   output logic [14:0]             mux_out
);

   localparam logic [2:0] EAST  = 3'd0;
   localparam logic [2:0] WEST  = 3'd1;
   localparam logic [2:0] NORTH = 3'd2;
   localparam logic [2:0] SOUTH = 3'd3;
   localparam logic [2:0] LOCAL = 3'd4;

   localparam logic [3:0] LX = ADDRESS[7:4];
   localparam logic [3:0] LY = ADDRESS[3:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANTED,
      S_ACTIVE
   } state_t;

   state_t     state_q   [5];
   state_t     state_d   [5];
   logic [2:0] ptr_q     [5];
   logic [2:0] ptr_d     [5];
   logic [2:0] mux_in_q  [5];
   logic [2:0] mux_in_d  [5];
   logic [2:0] mux_out_q [5];
   logic [2:0] mux_out_d [5];
   logic [4:0] free_q;
   logic [4:0] free_d;
   logic [4:0] ack_q;
   logic [4:0] ack_d;

   logic [2:0] route     [5];
   logic [4:0] req;
   logic [4:0] arb_found;
   logic [2:0] arb_win   [5];

   // Only the low byte of each head flit carries the destination.
   logic unused_flit_bits;
   assign unused_flit_bits = ^data_in;

   genvar gi;

   // Deterministic XY route per input; an input may only request while IDLE.
   for (gi = 0; gi < 5; gi++) begin : g_route
      logic [3:0] tx;
      logic [3:0] ty;
      assign tx = data_in[TAM_FLIT*gi+4 +: 4];
      assign ty = data_in[TAM_FLIT*gi +: 4];
      assign route[gi] = (tx > LX) ? EAST  :
                         (tx < LX) ? WEST  :
                         (ty > LY) ? NORTH :
                         (ty < LY) ? SOUTH : LOCAL;
      assign req[gi] = h[gi] && (state_q[gi] == S_IDLE);
   end

   // Round-robin per output: search starts one past the last winner.
   for (gi = 0; gi < 5; gi++) begin : g_arb
      logic       found;
      logic [2:0] win;
      logic [3:0] idx;
      always_comb begin
         found = 1'b0;
         win   = 3'd0;
         idx   = 4'd0;
         for (int k = 1; k <= 5; k++) begin
            idx = {1'b0, ptr_q[gi]} + 4'(k);
            if (idx >= 4'd5) begin
               idx = idx - 4'd5;
            end
            if (!found && req[idx[2:0]] && (route[idx[2:0]] == 3'(gi))) begin
               found = 1'b1;
               win   = idx[2:0];
            end
         end
         if (!free_q[gi]) begin
            found = 1'b0;
         end
      end
      assign arb_found[gi] = found;
      assign arb_win[gi]   = win;
   end

   always_comb begin
      free_d = free_q;
      ack_d  = '0;
      for (int i = 0; i < 5; i++) begin
         state_d[i]   = state_q[i];
         ptr_d[i]     = ptr_q[i];
         mux_in_d[i]  = mux_in_q[i];
         mux_out_d[i] = mux_out_q[i];
      end

      // Release frees only outputs that are currently allocated, so it never
      // collides with a grant below, which needs the registered free bit set.
      for (int i = 0; i < 5; i++) begin
         case (state_q[i])
            S_GRANTED: begin
               if (sender[i]) begin
                  state_d[i] = S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (!sender[i]) begin
                  state_d[i]             = S_IDLE;
                  free_d[mux_out_q[i]]   = 1'b1;
               end
            end
            default: ;
         endcase
      end

      for (int o = 0; o < 5; o++) begin
         if (arb_found[o]) begin
            free_d[o]               = 1'b0;
            ptr_d[o]                = arb_win[o];
            mux_in_d[o]             = arb_win[o];
            mux_out_d[arb_win[o]]   = 3'(o);
            ack_d[arb_win[o]]       = 1'b1;
            state_d[arb_win[o]]     = S_GRANTED;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         free_q <= '1;
         ack_q  <= '0;
         for (int i = 0; i < 5; i++) begin
            state_q[i]   <= S_IDLE;
            ptr_q[i]     <= 3'd4;
            mux_in_q[i]  <= 3'd0;
            mux_out_q[i] <= 3'd0;
         end
      end else begin
         free_q <= free_d;
         ack_q  <= ack_d;
         for (int i = 0; i < 5; i++) begin
            state_q[i]   <= state_d[i];
            ptr_q[i]     <= ptr_d[i];
            mux_in_q[i]  <= mux_in_d[i];
            mux_out_q[i] <= mux_out_d[i];
         end
      end
   end

   assign free  = free_q;
   assign ack_h = ack_q;

   for (gi = 0; gi < 5; gi++) begin : g_tables
      assign mux_in[3*gi +: 3]  = mux_in_q[gi];
      assign mux_out[3*gi +: 3] = mux_out_q[gi];
   end

endmodule

// File: doc/xy_port_allocator.md
# xy_port_allocator

Per-router output-port allocator for the 5-port Phoenix router. It takes header requests from the five input buffers, computes the XY route from each header flit, and grants free output ports. Contending inputs are served with a per-output round-robin. It drives the crossbar selection tables and the `free` vector, and releases an output when the owning input's packet ends. Because routing is deterministic, each input requests exactly one output, so all free outputs are allocated in parallel every cycle.

## Interface
- `ADDRESS`, default 8'h00: router coordinate, X = [7:4], Y = [3:0].
- `TAM_FLIT`, default 16: flit width. The destination coordinate is header bits [7:0], using the same X/Y split.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; all state is cleared while low.
- `h`  in  5: header pending per input port. Port indices: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- `data_in`  in  5*TAM_FLIT: head flit of each input buffer; input i occupies [TAM_FLIT*i +: TAM_FLIT].
- `sender`  in  5: input i is still transmitting its packet.
- `ack_h`  out  5: one-cycle header grant pulse per input.
- `free`  out  5: output o is unallocated (1) or allocated (0).
- `mux_in`  out  15: for output o, bits [3o+2:3o] give the index of the input driving it.
- `mux_out`  out  15: for input i, bits [3i+2:3i] give the index of the output it drives.

## Operation
- Route for input i, combinational from `data_in[i][7:0]` (tx, ty) versus `ADDRESS` (lx, ly):
  - tx>lx → EAST
  - tx<lx → WEST
  - else ty>ly → NORTH
  - else ty<ly → SOUTH
  - else LOCAL
- Comparisons are unsigned 4-bit.
- Per-input FSM with states IDLE, GRANTED, ACTIVE:
  - IDLE → GRANTED on grant.
  - GRANTED → ACTIVE when `sender[i]`=1.
  - ACTIVE → IDLE when `sender[i]`=0; this is the release.
  - GRANTED never releases, so the output stays held until `sender` has been seen high.
- Request: input i requests route(i) when `h[i]`=1 and its FSM is IDLE.
- Arbitration, per output o with registered `free[o]`=1:
  - Search inputs starting at ptr[o]+1 (mod 5); the first requester wins.
  - On a win: ptr[o] ← winner.
  - ptr[o] is unchanged when no requester is present.
- Grant of input i to output o, registered:
  - `free[o]`←0, `mux_in[o]`←i, `mux_out[i]`←o.
  - `ack_h[i]`←1 for exactly one cycle; FSM → GRANTED.
- Release of input i: `free[mux_out[i]]`←1. `mux_in`/`mux_out` keep their last values; the crossbar qualifies them with `free`.
- Routing to the requesting input's own port (U-turn) is not special-cased; it is granted like any other request.
- Independent outputs grant in the same cycle. Multiple `ack_h` bits may be high together.
- Width rules:
  - `ptr` is 3 bits, range 0..4, and wraps 4→0.
  - Table entries only ever hold 0..4.

## Timing
- Reset values (while `reset`=0):
  - `free`=5'b11111, `ack_h`=0, `mux_in`=0, `mux_out`=0.
  - All ptr=4, so the first search starts at EAST.
  - All FSMs IDLE.
- Grant latency: `h[i]` sampled at edge k with the output free → `ack_h[i]`, `free[o]`=0 and the table updates are all visible after edge k, for one cycle.
- `h[i]` still high during GRANTED or ACTIVE is ignored; no second ack is issued.
- Release: `sender[i]`=0 sampled in ACTIVE at edge m → `free[o]`=1 after edge m.
  - A waiting requester is granted at edge m+1 at the earliest.
  - A freeing output is never re-granted at the same edge.
- A released input returns to IDLE and may request again from edge m+1.
- Reset asserted mid-connection: all outputs are immediately free and `ack_h` drops asynchronously. Any pending ack is lost.

## Test plan
- Reset: hold `reset`=0 with random `h` and `sender` → `free`=5'b11111, `ack_h`=0, `mux_in`=`mux_out`=0. After release with h=0, outputs are unchanged.
- Single route, `ADDRESS`=8'h11: LOCAL header 8'h21 with h[4]=1 at edge k → after k, `ack_h`=5'b10000 for 1 cycle, `free[0]`=0, `mux_in[2:0]`=4, `mux_out[14:12]`=0. Then drive `sender[4]` 1→0 → `free[0]`=1 one edge after the fall.
- Route decode, `ADDRESS`=8'h11, headers 8'h21/8'h01/8'h12/8'h10/8'h11 → outputs EAST/WEST/NORTH/SOUTH/LOCAL.
- Contention: WEST, NORTH and LOCAL all target 8'h31 at once from reset → grant order 1, 2, 4. Each new ack comes one edge after the previous holder's release. Repeating the run with all three yields order 1, 2, 4 again (ptr=4).
- Parallel: EAST→8'h01 and WEST→8'h21 in the same cycle → `ack_h`=5'b00011 in one cycle; `free`=5'b11100.
- Hold and reset: grant, keep `sender` low (GRANTED) for 20 cycles → `free[o]` stays 0 with no re-ack. Assert `reset` mid-packet → `free`=5'b11111 immediately.
